// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache-miss line fill controller.
// On a miss it latches the line base, streams LINE_WORDS back-to-back 16-bit
// reads to pipelined memory, writes each returned word into the data array in
// issue order, and pulses write_tag_array with the last word. fsm_busy stalls
// the pipeline for the whole fill and is a direct decode of the state register.
//
// Handshake: there is no back-pressure. A read is issued on every cycle
// memory_enable is high. Memory answers each read, in order, after an arbitrary
// latency of at least one cycle by raising memory_data_valid for one cycle with
// the word on memory_data. Valids outside a fill, or beyond the last word of a
// line, are ignored.
//
// Optional feature: define CACHE_FILL_CWF_EN for critical-word-first ordering.
// The line is then fetched starting at the missing word and wrapping around,
// and early_restart flags the cycle that word is written. Without the macro the
// line is fetched in order 0..LINE_WORDS-1 and early_restart stays 0.
//
// While rst is low every control output is forced to 0 in that same cycle.

module cache_fill_fsm #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WORDS = 8,
  localparam int WB = $clog2(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  output logic                  fsm_busy,
  output logic                  memory_enable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data,
  output logic                  write_data_array,
  output logic [WB-1:0]         data_array_word,
  output logic [15:0]           data_array_wdata,
  output logic                  write_tag_array,
  output logic                  early_restart
);

  localparam int BW = ADDR_WIDTH - WB - 1;

  localparam logic [WB:0] CNT_LINE = (WB+1)'(LINE_WORDS);
  localparam logic [WB:0] CNT_LAST = (WB+1)'(LINE_WORDS - 1);
  localparam logic [WB:0] CNT_ONE  = (WB+1)'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  logic [0:0]    state;
  logic [WB:0]   issue_cnt;
  logic [WB:0]   recv_cnt;
  logic [BW-1:0] base;
  logic [WB-1:0] crit;

  logic          in_fill;
  logic          issue_go;
  logic          recv_go;
  logic          last_word;
  logic [WB-1:0] issue_off;
  logic [WB-1:0] recv_off;
  logic          crit_hit;

  // Byte bit 0 never reaches memory; crit only steers ordering in the CWF build.
  logic unused_bits;
  assign unused_bits = ^{miss_address[0], crit};

  // Decode the registered state into issue/return strobes and the line word offsets.
  always_comb begin
    in_fill   = rst & (state == S_FILL);
    issue_go  = in_fill & (issue_cnt < CNT_LINE);
    recv_go   = in_fill & memory_data_valid & (recv_cnt < CNT_LINE);
    last_word = recv_go & (recv_cnt == CNT_LAST);
`ifdef CACHE_FILL_CWF_EN
    issue_off = crit + issue_cnt[WB-1:0];
    recv_off  = crit + recv_cnt[WB-1:0];
    crit_hit  = recv_go & (recv_cnt == '0);
`else
    issue_off = issue_cnt[WB-1:0];
    recv_off  = recv_cnt[WB-1:0];
    crit_hit  = 1'b0;
`endif
  end

  // Drive the memory and array interfaces; everything but the data path is held low in reset.
  always_comb begin
    fsm_busy         = in_fill;
    memory_enable    = issue_go;
    memory_address   = rst ? {base, issue_off, 1'b0} : '0;
    write_data_array = recv_go;
    data_array_word  = rst ? recv_off : '0;
    data_array_wdata = memory_data;
    write_tag_array  = last_word;
    early_restart    = crit_hit;
  end

  // Fill sequencer: latch the miss in IDLE, count issues and returns in FILL,
  // and leave FILL on the edge after the last word is written. A miss seen in
  // the completion cycle is dropped; the cache raises it again once IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base      <= '0;
      crit      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss_detected) begin
            base      <= miss_address[ADDR_WIDTH-1:WB+1];
            crit      <= miss_address[WB:1];
            issue_cnt <= '0;
            recv_cnt  <= '0;
            state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (issue_go) begin
            issue_cnt <= issue_cnt + CNT_ONE;
          end
          if (recv_go) begin
            recv_cnt <= recv_cnt + CNT_ONE;
          end
          if (last_word) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed bench for cache_fill_fsm.
// u_dut uses 8-word lines and is served by a small in-order memory model with
// a programmable return delay; u_dut4 uses 4-word lines and is driven by hand.
// Expected read order follows CACHE_FILL_CWF_EN when the bench is built with it.

module tb_cache_fill_fsm;

  localparam int N = 8;

`ifdef CACHE_FILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- DUT (8-word line) ----------------
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address  = 16'h0;
  logic        fsm_busy, memory_enable, write_data_array, write_tag_array, early_restart;
  logic [15:0] memory_address, data_array_wdata;
  logic [2:0]  data_array_word;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        resp_valid  = 1'b0;
  logic [15:0] resp_data   = 16'h0;
  logic        stray_valid = 1'b0;

  assign memory_data_valid = resp_valid | stray_valid;
  assign memory_data       = resp_data;

  cache_fill_fsm #(.ADDR_WIDTH(16), .LINE_WORDS(8)) u_dut (
    .clk(clk), .rst(rst),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .fsm_busy(fsm_busy), .memory_enable(memory_enable), .memory_address(memory_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .write_data_array(write_data_array), .data_array_word(data_array_word),
    .data_array_wdata(data_array_wdata), .write_tag_array(write_tag_array),
    .early_restart(early_restart)
  );

  // ---------------- DUT (4-word line) ----------------
  logic        m4_miss = 1'b0;
  logic [15:0] m4_addr = 16'h0;
  logic        m4_valid = 1'b0;
  logic [15:0] m4_data = 16'h0;
  logic        m4_busy, m4_en, m4_wr, m4_tag, m4_er;
  logic [15:0] m4_maddr, m4_wdata;
  logic [1:0]  m4_word;

  cache_fill_fsm #(.ADDR_WIDTH(16), .LINE_WORDS(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .miss_detected(m4_miss), .miss_address(m4_addr),
    .fsm_busy(m4_busy), .memory_enable(m4_en), .memory_address(m4_maddr),
    .memory_data_valid(m4_valid), .memory_data(m4_data),
    .write_data_array(m4_wr), .data_array_word(m4_word),
    .data_array_wdata(m4_wdata), .write_tag_array(m4_tag),
    .early_restart(m4_er)
  );

  // ---------------- memory model ----------------
  // Each read seen at a negedge is answered resp_lat cycles later with addr ^ 16'h5A5A.
  int          resp_lat = 3;
  logic [15:0] pa_q[$];
  int          pd_q[$];

  initial forever begin
    @(negedge clk);
    if (memory_enable === 1'b1) begin
      pa_q.push_back(memory_address);
      pd_q.push_back(cyc + resp_lat);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (pd_q.size() > 0 && pd_q[0] <= cyc) begin
      resp_valid = 1'b1;
      resp_data  = pa_q.pop_front() ^ 16'h5A5A;
      void'(pd_q.pop_front());
    end else begin
      resp_valid = 1'b0;
      resp_data  = 16'h0;
    end
  end

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] off8(input logic [2:0] crit, input int n);
    logic [2:0] k;
    k = 3'(n);
    return CWF ? (crit + k) : k;
  endfunction

  // ---------------- driver tasks ----------------
  // One miss on u_dut starting in the current (idle) cycle, checked cycle by cycle.
  // Read issued on cycle c returns on cycle c+lat. abort_at>0 pulls rst low on that cycle.
  // hold_miss keeps miss_detected high with hold_addr until the completion cycle.
  task automatic fill(input logic [15:0] addr, input int lat, input int abort_at,
                      input bit hold_miss, input logic [15:0] hold_addr, input string tag);
    logic [2:0]  crit;
    logic [15:0] base;
    logic [2:0]  woff;
    logic [15:0] ea;
    bit          ab, e_busy, e_en, e_wr, e_tag, e_er;
    crit = addr[3:1];
    base = {addr[15:4], 4'h0};
    resp_lat = lat;
    miss_detected = 1'b1;
    miss_address  = addr;
    @(negedge clk);
    chk({tag, "_busy_c0"}, fsm_busy, 0);
    @(posedge clk);
    #1;
    for (int c = 1; c <= N + lat + 1; c++) begin
      if (hold_miss && c <= N + lat) begin
        miss_detected = 1'b1;
        miss_address  = hold_addr;
      end else begin
        miss_detected = 1'b0;
      end
      rst = (abort_at != 0 && c == abort_at) ? 1'b0 : 1'b1;
      ab     = (abort_at != 0) && (c >= abort_at);
      e_busy = !ab && c <= N + lat;
      e_en   = !ab && c <= N;
      e_wr   = !ab && c > lat && c <= lat + N;
      e_tag  = !ab && c == lat + N;
      e_er   = CWF && e_wr && c == lat + 1;
      @(negedge clk);
      chk($sformatf("%s_busy_c%0d", tag, c), fsm_busy, e_busy);
      chk($sformatf("%s_en_c%0d", tag, c), memory_enable, e_en);
      chk($sformatf("%s_wr_c%0d", tag, c), write_data_array, e_wr);
      chk($sformatf("%s_tag_c%0d", tag, c), write_tag_array, e_tag);
      chk($sformatf("%s_er_c%0d", tag, c), early_restart, e_er);
      if (e_en) begin
        woff = off8(crit, c - 1);
        ea   = base | {12'h0, woff, 1'b0};
        chk($sformatf("%s_addr_c%0d", tag, c), memory_address, ea);
      end
      if (e_wr) begin
        woff = off8(crit, c - 1 - lat);
        ea   = base | {12'h0, woff, 1'b0};
        chk($sformatf("%s_word_c%0d", tag, c), data_array_word, woff);
        chk($sformatf("%s_wdata_c%0d", tag, c), data_array_wdata, ea ^ 16'h5A5A);
      end
      @(posedge clk);
      #1;
    end
    miss_detected = 1'b0;
    rst = 1'b1;
  endtask

  // Stray memory_data_valid pulses while idle must not write anything.
  task automatic stray(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      stray_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("%s_wr_%0d", tag, i), write_data_array, 0);
      chk($sformatf("%s_tag_%0d", tag, i), write_tag_array, 0);
      chk($sformatf("%s_busy_%0d", tag, i), fsm_busy, 0);
      @(posedge clk);
      #1;
    end
    stray_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [15:0] t6_addr[4];
  logic [1:0]  t6_word[4];

  initial begin
`ifdef CACHE_FILL_CWF_EN
    t6_addr = '{16'hFFFE, 16'hFFF8, 16'hFFFA, 16'hFFFC};
    t6_word = '{2'd3, 2'd0, 2'd1, 2'd2};
`else
    t6_addr = '{16'hFFF8, 16'hFFFA, 16'hFFFC, 16'hFFFE};
    t6_word = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif

    // Reset held low: outputs are zero even before the first edge.
    @(negedge clk);
    chk("rst_busy", fsm_busy, 0);
    chk("rst_en", memory_enable, 0);
    chk("rst_addr", memory_address, 0);
    chk("rst_wr", write_data_array, 0);
    chk("rst_tag", write_tag_array, 0);
    chk("rst_er", early_restart, 0);
    chk("rst_busy4", m4_busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", fsm_busy, 0);
    chk("idle_en", memory_enable, 0);
    chk("idle_addr", memory_address, 0);
    chk("idle_wr", write_data_array, 0);
    @(posedge clk);
    #1;

    // T1: in-order line, reads on cycles 1..8, writes 4..11, tag on 11.
    fill(16'h1236, 3, 0, 1'b0, 16'h0, "t1");
    // T2: miss in word 5 (critical word first when enabled).
    fill(16'h123A, 3, 0, 1'b0, 16'h0, "t2");
    // T3: reset on the 4th return; no tag, later valids ignored.
    fill(16'h1236, 3, 7, 1'b0, 16'h0, "t3");
    // T4: miss held with 0x4000 through a fill, then re-asserted.
    fill(16'h2468, 3, 0, 1'b1, 16'h4000, "t4a");
    fill(16'h4000, 3, 0, 1'b0, 16'h0, "t4b");
    // T5: latency 1 with stray valids before and after.
    stray(2, "t5pre");
    fill(16'h0102, 1, 0, 1'b0, 16'h0, "t5");
    stray(2, "t5post");

    // T6: 4-word line at the top of the address space, one-cycle return.
    m4_miss = 1'b1;
    m4_addr = 16'hFFFE;
    @(negedge clk);
    chk("t6_busy_c0", m4_busy, 0);
    @(posedge clk);
    #1;
    m4_miss = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      m4_valid = (c >= 2 && c <= 5);
      m4_data  = 16'hC000 + 16'(c);
      @(negedge clk);
      chk($sformatf("t6_busy_c%0d", c), m4_busy, (c <= 5));
      chk($sformatf("t6_en_c%0d", c), m4_en, (c <= 4));
      chk($sformatf("t6_wr_c%0d", c), m4_wr, (c >= 2 && c <= 5));
      chk($sformatf("t6_tag_c%0d", c), m4_tag, (c == 5));
      chk($sformatf("t6_er_c%0d", c), m4_er, (CWF && c == 2));
      if (c <= 4) begin
        chk($sformatf("t6_addr_c%0d", c), m4_maddr, t6_addr[c-1]);
      end
      if (c >= 2 && c <= 5) begin
        chk($sformatf("t6_word_c%0d", c), m4_word, t6_word[c-2]);
        chk($sformatf("t6_wdata_c%0d", c), m4_wdata, 16'hC000 + 16'(c));
      end
      @(posedge clk);
      #1;
    end
    m4_valid = 1'b0;

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
